pool_row_reducer: RTL

//  Parametrised KxK (K=2 or 4) stride-K pooling stage after the post-processing unit.

---
 rtl/pool_pkg.sv | 27 ++
 rtl/pool_lane.sv | 70 +++++++
 rtl/pool_row_reducer.sv | 101 ++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and elaboration helpers for the pool_row_reducer slice.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic {
    WIN_EMPTY   = 1'b0,
    WIN_FILLING = 1'b1
  } win_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit pool_k_legal(input int unsigned k);
    return (k == 2) || (k == 4);
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One output lane: K-element row reduce, window accumulator, final max or floor-average.
// Average datapath only exists when POOL_AVG_EN is defined.
module pool_lane
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned POOL_K = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [POOL_K*DATA_W-1:0] row_data,
  input  logic                     load,
  input  logic                     combine,
  input  logic                     clear,
`ifdef POOL_AVG_EN
  input  pool_mode_e               mode,
`endif
  output logic [DATA_W-1:0]        result
);

`ifdef POOL_AVG_EN
  localparam int unsigned SHIFT = 2 * clog2(POOL_K);
  localparam int unsigned ACC_W = DATA_W + SHIFT;
`else
  localparam int unsigned ACC_W = DATA_W;
`endif

  logic signed [DATA_W-1:0] elem [POOL_K];
  logic signed [DATA_W-1:0] row_max;
  logic signed [ACC_W-1:0]  row_val;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
`ifdef POOL_AVG_EN
  logic signed [ACC_W-1:0]  row_sum;
`endif

  always_comb begin
    for (int unsigned i = 0; i < POOL_K; i++) begin
      elem[i] = row_data[i*DATA_W +: DATA_W];
    end
    row_max = elem[0];
    for (int unsigned i = 1; i < POOL_K; i++) begin
      if (elem[i] > row_max) row_max = elem[i];
    end
`ifdef POOL_AVG_EN
    // Sum is sign-extended to the full accumulator width, so it is exact for K*K terms.
    row_sum = '0;
    for (int unsigned i = 0; i < POOL_K; i++) begin
      row_sum = row_sum + ACC_W'(elem[i]);
    end
    row_val = (mode == POOL_AVG) ? row_sum : ACC_W'(row_max);
    if (load)                  acc_nxt = row_val;
    else if (mode == POOL_AVG) acc_nxt = acc + row_val;
    else                       acc_nxt = (row_val > acc) ? row_val : acc;
    result = (mode == POOL_AVG) ? DATA_W'(acc_nxt >>> SHIFT) : DATA_W'(acc_nxt);
`else
    row_val = row_max;
    if (load) acc_nxt = row_val;
    else      acc_nxt = (row_val > acc) ? row_val : acc;
    result = acc_nxt;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  acc <= '0;
    else if (clear)            acc <= '0;
    else if (load || combine)  acc <= acc_nxt;
  end

endmodule

// File: rtl/pool_row_reducer.sv
// KxK stride-K signed pooling stage (max, plus average when POOL_AVG_EN is defined).
// Owns the row counter, mode latch, flush handling and output register.
module pool_row_reducer
  import pool_pkg::*;
#(
  parameter int unsigned POX    = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned POOL_K = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [POX*DATA_W-1:0]         in_data,
  input  logic                          in_valid,
  input  logic                          pool_mode,
  input  logic                          pool_flush,
  output logic [POX/POOL_K*DATA_W-1:0]  out_data,
  output logic                          out_valid,
  output logic                          win_busy
);

  localparam int unsigned LANES_OUT = POX / POOL_K;
  localparam int unsigned RC_W      = clog2(POOL_K);
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(POOL_K - 1);

  if (!pool_k_legal(POOL_K)) begin : g_bad_k
    $error("pool_row_reducer: POOL_K must be 2 or 4");
  end
  if ((POX % POOL_K) != 0) begin : g_bad_pox
    $error("pool_row_reducer: POX must be a multiple of POOL_K");
  end

  win_state_e               state;
  logic [RC_W-1:0]          row_cnt;
  logic [RC_W-1:0]          row_cnt_nxt;
  logic                     beat;
  logic                     first_beat;
  logic                     last_beat;
  logic [LANES_OUT*DATA_W-1:0] lane_res;

  // Flush overrides a coincident beat, including the last beat of a window.
  always_comb begin
    state       = (row_cnt == '0) ? WIN_EMPTY : WIN_FILLING;
    beat        = in_valid && !pool_flush;
    first_beat  = beat && (state == WIN_EMPTY);
    last_beat   = beat && (row_cnt == LAST_ROW);
    row_cnt_nxt = row_cnt;
    if (pool_flush)  row_cnt_nxt = '0;
    else if (beat)   row_cnt_nxt = last_beat ? '0 : row_cnt + RC_W'(1);
    win_busy    = (state == WIN_FILLING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) row_cnt <= '0;
    else      row_cnt <= row_cnt_nxt;
  end

`ifdef POOL_AVG_EN
  pool_mode_e mode_q;
  pool_mode_e mode_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            mode_q <= POOL_MAX;
    else if (first_beat) mode_q <= pool_mode_e'(pool_mode);
  end

  // The first beat of a window is reduced with the live mode, later beats with the latched one.
  assign mode_eff = (state == WIN_EMPTY) ? pool_mode_e'(pool_mode) : mode_q;
`else
  logic unused_mode;
  assign unused_mode = pool_mode;
`endif

  for (genvar j = 0; j < LANES_OUT; j++) begin : g_lane
    pool_lane #(
      .DATA_W (DATA_W),
      .POOL_K (POOL_K)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .row_data (in_data[j*POOL_K*DATA_W +: POOL_K*DATA_W]),
      .load     (first_beat),
      .combine  (beat && !first_beat),
      .clear    (pool_flush),
`ifdef POOL_AVG_EN
      .mode     (mode_eff),
`endif
      .result   (lane_res[j*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= last_beat;
      if (last_beat) out_data <= lane_res;
    end
  end

endmodule
